// File: rtl/sum_nb_serial.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock, LSB digit first,
// and pulses done after WIDTH/DIGIT run cycles with sum, carry out and overflow.
module sum_nb_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // state | meaning
    // IDLE  | waiting for start; results from the last operation held
    // RUN   | one digit processed per clock, LSB digit first

    localparam int D  = WIDTH / DIGIT;
    localparam int IW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             done_q;
    logic             busy_q;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dres;
    logic             last;

    always_comb begin
        a_dig = a_q[int'(idx_q)*DIGIT +: DIGIT];
        b_dig = b_q[int'(idx_q)*DIGIT +: DIGIT];
        dres  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
        last  = (idx_q == IW'(D - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        // subtraction is a + ~b + 1; the carry register supplies the +1
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub | cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[int'(idx_q)*DIGIT +: DIGIT] <= dres[DIGIT-1:0];
                    carry_q <= dres[DIGIT];
                    if (last) begin
                        cout_q  <= dres[DIGIT];
                        // a^b^s at the MSB recovers the carry into the MSB
                        ovf_q   <= a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dres[DIGIT-1] ^ dres[DIGIT];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_sum_nb_serial.sv
// Scoreboard bench for sum_nb_serial in three digit configurations: expected
// results are queued at start and matched against each done pulse.
module tb_sum_nb_serial;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=16 DIGIT=4
    logic start0 = 0, cin0 = 0, sub0 = 0, busy0, done0, cout0, ovf0;
    logic [15:0] a0 = '0, b0 = '0, sum0;
    // WIDTH=5 DIGIT=1
    logic start1 = 0, cin1 = 0, sub1 = 0, busy1, done1, cout1, ovf1;
    logic [4:0] a1 = '0, b1 = '0, sum1;
    // WIDTH=8 DIGIT=8
    logic start2 = 0, cin2 = 0, sub2 = 0, busy2, done2, cout2, ovf2;
    logic [7:0] a2 = '0, b2 = '0, sum2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    sum_nb_serial #(.WIDTH(16), .DIGIT(4)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .cin(cin0), .sub(sub0),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0));
    sum_nb_serial #(.WIDTH(5), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));
    sum_nb_serial #(.WIDTH(8), .DIGIT(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b,
                                   logic cin, logic sub, int due);
        exp_t r;
        logic [16:0] mask, be, full;
        logic am, bm, sm;
        mask  = (17'd1 << w) - 17'd1;
        be    = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        full  = ({1'b0, a} & mask) + be + {16'd0, (sub ? 1'b1 : cin)};
        am    = a[w-1];
        bm    = be[w-1];
        sm    = full[w-1];
        r.s   = full[15:0] & mask[15:0];
        r.co  = full[w];
        r.ov  = (am == bm) && (sm != am);
        r.due = due;
        return r;
    endfunction

    // Drive one accepted operation at the current negedge; returns at its done cycle.
    task automatic op(int cfg, logic [15:0] a, logic [15:0] b, logic cin, logic sub);
        int d;
        case (cfg)
            0: begin
                d = 4; a0 = a; b0 = b; cin0 = cin; sub0 = sub; start0 = 1;
                q0.push_back(model(16, a, b, cin, sub, cyc + 1 + d));
            end
            1: begin
                d = 5; a1 = a[4:0]; b1 = b[4:0]; cin1 = cin; sub1 = sub; start1 = 1;
                q1.push_back(model(5, a, b, cin, sub, cyc + 1 + d));
            end
            default: begin
                d = 1; a2 = a[7:0]; b2 = b[7:0]; cin2 = cin; sub2 = sub; start2 = 1;
                q2.push_back(model(8, a, b, cin, sub, cyc + 1 + d));
            end
        endcase
        @(negedge clk);
        start0 = 0; start1 = 0; start2 = 0;
        repeat (d) @(negedge clk);
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        if (done0) begin
            if (q0.size() == 0) chk("w16_spurious_done", {31'd0, done0}, 32'd0);
            else begin
                e = q0.pop_front();
                chk("w16_latency", cyc, e.due);
                chk("w16_sum", {16'd0, sum0}, {16'd0, e.s});
                chk("w16_cout", {31'd0, cout0}, {31'd0, e.co});
                chk("w16_ovf", {31'd0, ovf0}, {31'd0, e.ov});
            end
        end else if (q0.size() > 0 && q0[0].due <= cyc) begin
            chk("w16_missing_done", {31'd0, done0}, 32'd1);
            void'(q0.pop_front());
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (done1) begin
            if (q1.size() == 0) chk("w5_spurious_done", {31'd0, done1}, 32'd0);
            else begin
                e = q1.pop_front();
                chk("w5_latency", cyc, e.due);
                chk("w5_sum", {27'd0, sum1}, {16'd0, e.s});
                chk("w5_cout", {31'd0, cout1}, {31'd0, e.co});
                chk("w5_ovf", {31'd0, ovf1}, {31'd0, e.ov});
            end
        end else if (q1.size() > 0 && q1[0].due <= cyc) begin
            chk("w5_missing_done", {31'd0, done1}, 32'd1);
            void'(q1.pop_front());
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (done2) begin
            if (q2.size() == 0) chk("w8_spurious_done", {31'd0, done2}, 32'd0);
            else begin
                e = q2.pop_front();
                chk("w8_latency", cyc, e.due);
                chk("w8_sum", {24'd0, sum2}, {16'd0, e.s});
                chk("w8_cout", {31'd0, cout2}, {31'd0, e.co});
                chk("w8_ovf", {31'd0, ovf2}, {31'd0, e.ov});
            end
        end else if (q2.size() > 0 && q2[0].due <= cyc) begin
            chk("w8_missing_done", {31'd0, done2}, 32'd1);
            void'(q2.pop_front());
        end
    end

    initial begin
        exp_t h;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_sum", {16'd0, sum0}, 32'd0);
        chk("rst_cout", {31'd0, cout0}, 32'd0);
        chk("rst_ovf", {31'd0, ovf0}, 32'd0);
        chk("rst_w5_busy", {31'd0, busy1}, 32'd0);
        chk("rst_w8_sum", {24'd0, sum2}, 32'd0);

        // first start on the first edge with rst low, then back-to-back directed ops
        rst = 0;
        op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op(0, 16'h0005, 16'h0007, 1'b1, 1'b1);
        @(negedge clk);

        // start held during RUN with different operands must be ignored
        a0 = 16'h1234; b0 = 16'h1111; cin0 = 0; sub0 = 0; start0 = 1;
        q0.push_back(model(16, 16'h1234, 16'h1111, 1'b0, 1'b0, cyc + 1 + 4));
        @(negedge clk);
        chk("run_busy", {31'd0, busy0}, 32'd1);
        a0 = 16'hAAAA; b0 = 16'h5555; cin0 = 1; sub0 = 1;
        repeat (2) @(negedge clk);
        start0 = 0;
        @(negedge clk);
        chk("run_busy_late", {31'd0, busy0}, 32'd1);
        @(negedge clk);
        op(0, 16'h0F0F, 16'h00F1, 1'b1, 1'b0);

        // results hold while idle
        repeat (3) @(negedge clk);
        h = model(16, 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 0);
        chk("idle_hold_sum", {16'd0, sum0}, {16'd0, h.s});
        chk("idle_busy", {31'd0, busy0}, 32'd0);
        chk("idle_done", {31'd0, done0}, 32'd0);

        // reset on the 2nd RUN edge aborts with no done pulse
        a0 = 16'h1111; b0 = 16'h2222; cin0 = 0; sub0 = 0; start0 = 1;
        @(negedge clk);
        start0 = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_done", {31'd0, done0}, 32'd0);
        chk("abort_sum", {16'd0, sum0}, 32'd0);
        chk("abort_cout", {31'd0, cout0}, 32'd0);
        rst = 0;
        repeat (6) @(negedge clk);

        // boundary directed ops in the other configurations
        op(1, 16'h001F, 16'h0001, 1'b0, 1'b0);
        op(1, 16'h000F, 16'h0001, 1'b0, 1'b0);
        op(1, 16'h0003, 16'h0005, 1'b0, 1'b1);
        op(2, 16'h00FF, 16'h0001, 1'b0, 1'b0);
        op(2, 16'h007F, 16'h0001, 1'b1, 1'b0);
        op(2, 16'h0080, 16'h0001, 1'b0, 1'b1);

        for (int i = 0; i < 1000; i++)
            op(0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 200; i++)
            op(1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 200; i++)
            op(2, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        repeat (3) @(negedge clk);
        chk("w16_queue_drained", q0.size(), 32'd0);
        chk("w5_queue_drained", q1.size(), 32'd0);
        chk("w8_queue_drained", q2.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_nb_serial.md
SUM_NB_SERIAL -- requirements
Module: sum_nb_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, bits added per clock.
REQ-003 WIDTH SHALL be an integer multiple of DIGIT, with DIGIT >= 1; D = WIDTH/DIGIT denotes digit count.
REQ-004 Port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port start, input, 1 bit: request a new operation.
REQ-007 Port a, input, WIDTH bits: operand A, sampled only on an accepted start.
REQ-008 Port b, input, WIDTH bits: operand B, sampled only on an accepted start.
REQ-009 Port cin, input, 1 bit: carry-in, sampled only on an accepted start.
REQ-010 Port sub, input, 1 bit: 0 = add, 1 = subtract; sampled only on an accepted start.
REQ-011 Port busy, output, 1 bit: high while an operation is in progress.
REQ-012 Port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-013 Port sum, output, WIDTH bits: result.
REQ-014 Port cout, output, 1 bit: carry out of the MSB (for sub = 1, 1 means no borrow).
REQ-015 Port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 States SHALL be IDLE and RUN only.
REQ-017 start SHALL be accepted when the state is IDLE at the rising edge, including the cycle in which done is high.
REQ-018 start SHALL be ignored while the state is RUN; latched operands and progress SHALL be unchanged.
REQ-019 On acceptance, the block SHALL latch a, b, cin and sub, then enter RUN with digit index 0 and carry register = (sub ? 1 : cin).
REQ-020 For sub = 1, the block SHALL use ~b as the addend and ignore cin, computing a - b mod 2^WIDTH.
REQ-021 Each RUN edge SHALL add digit i of A, digit i of the effective B and the carry register; it SHALL write DIGIT sum bits to sum[i*DIGIT +: DIGIT], store the carry and increment i.
REQ-022 Digits SHALL be processed LSB first, index 0 up to D-1.
REQ-023 The edge processing digit D-1 SHALL set cout to the final carry, set ovf = carry into MSB XOR carry out of MSB, pulse done high, and return to IDLE.
REQ-024 Latency: done SHALL be high in the cycle following the D-th rising edge after the edge that accepted start; with the defaults this is 4 edges.
REQ-025 busy SHALL be high exactly during the D cycles the block is in RUN.
REQ-026 done SHALL be high for exactly one cycle per accepted operation.
REQ-027 sum, cout and ovf SHALL hold their last final values in IDLE until the next accepted operation.
REQ-028 sum bits SHALL be undefined for the verifier from acceptance until done; only values at done and while idle are checked.
REQ-029 Accumulation SHALL be internal, modulo 2^WIDTH; no bit beyond WIDTH SHALL reach sum.
REQ-030 A back-to-back start in the done cycle SHALL begin a new operation with no idle gap.

Reset
REQ-031 With rst high at a rising edge, the block SHALL enter IDLE with busy = 0, done = 0, sum = 0, cout = 0, ovf = 0, digit index 0 and carry 0.
REQ-032 rst SHALL take priority over start and abort any RUN in progress without a done pulse.
REQ-033 The first start SHALL be accepted on the first edge with rst low.

Verification (WIDTH=16, DIGIT=4)
REQ-034 Bench SHALL apply a=0xFFFF, b=0x0001, cin=0, sub=0 -> done on the 4th edge with sum=0x0000, cout=1, ovf=0.
REQ-035 Bench SHALL apply a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1.
REQ-036 Bench SHALL apply a=0x0005, b=0x0007, cin=1, sub=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
REQ-037 Bench SHALL assert start with new operands during RUN -> they are ignored and the original result appears at the original done time; a start in the done cycle is accepted and completes 4 edges later.
REQ-038 Bench SHALL assert rst on the 2nd RUN edge -> next cycle busy=0, done=0, sum=0, and no done pulse follows.
REQ-039 Bench SHALL run 1000 random a, b, cin, sub, plus configurations WIDTH=5/DIGIT=1 and WIDTH=8/DIGIT=8 -> results match the reference model a +/- b (+cin) and latency is always D.
